// File: rtl/serial_controller.sv
// -----------------------------------------------------------------------------
// serial_controller
//
// Purpose:
//   Serial line engine between the APB slave and the off-chip keyboard/mouse
//   link.
//   TX: when the slave pulses transmit, the byte on tx_data is shifted out on
//       txd as a UART frame. tx_done pulses for one cycle when the frame ends.
//   RX: rxd is synchronised and deserialised. A good byte appears on rx_data
//       and receive stays high until the slave pulses rx_done.
//
// Frame format:
//   start(0), d[0]..d[7] LSB first, [even parity], stop(1).
//   Each bit lasts CLKS_PER_BIT pclk cycles.
//
// Build option:
//   SERIAL_PARITY_EN
//     Defined: an even-parity bit (^data) follows d[7]. On RX, a parity
//       mismatch is reported like a bad stop bit.
//     Undefined: plain 8N1 framing. No parity state is built.
//
// Parameters:
//   CLKS_PER_BIT  pclk cycles per serial bit. Must be even and >= 4.
//
// Ports:
//   pclk          in   1  clock, rising edge
//   preset        in   1  asynchronous, active-high reset
//   transmit      in   1  TX request; only looked at while TX is idle
//   tx_data       in   8  byte to send; captured when transmit is accepted
//   tx_done       out  1  one-cycle pulse when the TX frame completes
//   rx_data       out  8  last good received byte
//   receive       out  1  a received byte is pending
//   rx_done       in   1  slave has consumed rx_data
//   txd           out  1  serial out; idles high
//   rxd           in   1  serial in; asynchronous
//   rx_frame_err  out  1  one-cycle pulse: bad stop (or parity) bit
//   rx_overrun    out  1  one-cycle pulse: good byte dropped, receive was busy
// -----------------------------------------------------------------------------
module serial_controller #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       transmit,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       receive,
  input  logic       rx_done,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
`ifdef SERIAL_PARITY_EN
    T_PARITY = 3'd3,
`endif
    T_STOP   = 3'd4,
    T_DONE   = 3'd5
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
`ifdef SERIAL_PARITY_EN
    R_PARITY = 3'd3,
`endif
    R_STOP   = 3'd4
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t       r_tx_state;
  tx_state_t       w_tx_state_next;
  logic [CW-1:0]   r_tx_cnt;
  logic [CW-1:0]   w_tx_cnt_next;
  logic [2:0]      r_tx_bit;
  logic [2:0]      w_tx_bit_next;
  logic [7:0]      r_tx_shift;
  logic [7:0]      w_tx_shift_next;
  logic            r_txd;
  logic            w_txd_next;
  logic            r_tx_done;
  logic            w_tx_done_next;
  logic            w_tx_bit_end;
`ifdef SERIAL_PARITY_EN
  logic            r_tx_par;
  logic            w_tx_par_next;
`endif

  assign w_tx_bit_end = (r_tx_cnt == C_BIT_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
      r_tx_done  <= w_tx_done_next;
`ifdef SERIAL_PARITY_EN
      r_tx_par   <= w_tx_par_next;
`endif
    end
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_txd_next      = 1'b1;
    w_tx_done_next  = 1'b0;
`ifdef SERIAL_PARITY_EN
    w_tx_par_next   = r_tx_par;
`endif

    case (r_tx_state)
      T_IDLE: begin
        if (transmit) begin
          w_tx_shift_next = tx_data;
          w_tx_cnt_next   = '0;
          w_tx_bit_next   = '0;
          w_tx_state_next = T_START;
`ifdef SERIAL_PARITY_EN
          w_tx_par_next   = ^tx_data;
`endif
        end
      end
      T_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = T_DATA;
        end else begin
          w_tx_cnt_next = r_tx_cnt + C_ONE;
        end
      end
      T_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          // The bit on the line is always shift[0]; advance at bit boundaries.
          w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) begin
            w_tx_bit_next   = '0;
`ifdef SERIAL_PARITY_EN
            w_tx_state_next = T_PARITY;
`else
            w_tx_state_next = T_STOP;
`endif
          end else begin
            w_tx_bit_next = r_tx_bit + 3'd1;
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + C_ONE;
        end
      end
`ifdef SERIAL_PARITY_EN
      T_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = T_STOP;
        end else begin
          w_tx_cnt_next = r_tx_cnt + C_ONE;
        end
      end
`endif
      T_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = T_DONE;
        end else begin
          w_tx_cnt_next = r_tx_cnt + C_ONE;
        end
      end
      T_DONE: begin
        w_tx_state_next = T_IDLE;
      end
      default: begin
        w_tx_state_next = T_IDLE;
        w_tx_cnt_next   = '0;
        w_tx_bit_next   = '0;
      end
    endcase

    // txd and tx_done are registered from the next state so the pins never
    // see decode glitches and line up exactly with the state they belong to.
    case (w_tx_state_next)
      T_START:  w_txd_next = 1'b0;
      T_DATA:   w_txd_next = w_tx_shift_next[0];
`ifdef SERIAL_PARITY_EN
      T_PARITY: w_txd_next = w_tx_par_next;
`endif
      default:  w_txd_next = 1'b1;
    endcase
    w_tx_done_next = (w_tx_state_next == T_DONE);
  end

  assign txd     = r_txd;
  assign tx_done = r_tx_done;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            r_rxd_meta;
  logic            r_rxd_sync;
  logic            r_rxd_prev;
  rx_state_t       r_rx_state;
  rx_state_t       w_rx_state_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [CW-1:0]   w_rx_cnt_next;
  logic [2:0]      r_rx_bit;
  logic [2:0]      w_rx_bit_next;
  logic [7:0]      r_rx_shift;
  logic [7:0]      w_rx_shift_next;
  logic [7:0]      r_rx_data;
  logic [7:0]      w_rx_data_next;
  logic            r_receive;
  logic            w_receive_next;
  logic            r_rx_frame_err;
  logic            w_rx_frame_err_next;
  logic            r_rx_overrun;
  logic            w_rx_overrun_next;
  logic            w_rx_fall;
  logic            w_rx_bit_end;
  logic            w_rx_frame_ok;
`ifdef SERIAL_PARITY_EN
  logic            r_rx_par_err;
  logic            w_rx_par_err_next;
`endif

  // Two-flop synchroniser plus one extra stage for edge detection. Resetting
  // to 1 (idle line) keeps reset release from looking like a start bit.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // Only a 1->0 transition arms the receiver. After a bad stop bit the line
  // may still be low; no new frame starts until it has been seen high again.
  assign w_rx_fall    = r_rxd_prev & ~r_rxd_sync;
  assign w_rx_bit_end = (r_rx_cnt == C_BIT_LAST);

`ifdef SERIAL_PARITY_EN
  assign w_rx_frame_ok = r_rxd_sync & ~r_rx_par_err;
`else
  assign w_rx_frame_ok = r_rxd_sync;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rx_state     <= R_IDLE;
      r_rx_cnt       <= '0;
      r_rx_bit       <= '0;
      r_rx_shift     <= '0;
      r_rx_data      <= '0;
      r_receive      <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_overrun   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      r_rx_par_err   <= 1'b0;
`endif
    end else begin
      r_rx_state     <= w_rx_state_next;
      r_rx_cnt       <= w_rx_cnt_next;
      r_rx_bit       <= w_rx_bit_next;
      r_rx_shift     <= w_rx_shift_next;
      r_rx_data      <= w_rx_data_next;
      r_receive      <= w_receive_next;
      r_rx_frame_err <= w_rx_frame_err_next;
      r_rx_overrun   <= w_rx_overrun_next;
`ifdef SERIAL_PARITY_EN
      r_rx_par_err   <= w_rx_par_err_next;
`endif
    end
  end

  always_comb begin
    w_rx_state_next     = r_rx_state;
    w_rx_cnt_next       = r_rx_cnt;
    w_rx_bit_next       = r_rx_bit;
    w_rx_shift_next     = r_rx_shift;
    w_rx_data_next      = r_rx_data;
    // rx_done only has an effect while a byte is pending.
    w_receive_next      = r_receive & ~rx_done;
    w_rx_frame_err_next = 1'b0;
    w_rx_overrun_next   = 1'b0;
`ifdef SERIAL_PARITY_EN
    w_rx_par_err_next   = r_rx_par_err;
`endif

    case (r_rx_state)
      R_IDLE: begin
        if (w_rx_fall) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = '0;
          w_rx_state_next = R_START;
        end
      end
      R_START: begin
        // Mid-start check; every later sample is a whole bit after this one.
        if (r_rx_cnt == C_HALF_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = r_rxd_sync ? R_IDLE : R_DATA;
        end else begin
          w_rx_cnt_next = r_rx_cnt + C_ONE;
        end
      end
      R_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rxd_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_bit_next   = '0;
`ifdef SERIAL_PARITY_EN
            w_rx_state_next = R_PARITY;
`else
            w_rx_state_next = R_STOP;
`endif
          end else begin
            w_rx_bit_next = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + C_ONE;
        end
      end
`ifdef SERIAL_PARITY_EN
      R_PARITY: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next     = '0;
          w_rx_par_err_next = r_rxd_sync ^ (^r_rx_shift);
          w_rx_state_next   = R_STOP;
        end else begin
          w_rx_cnt_next = r_rx_cnt + C_ONE;
        end
      end
`endif
      R_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = R_IDLE;
          if (w_rx_frame_ok) begin
            // A consume in the same cycle frees the holding register, so the
            // new byte is accepted instead of being counted as an overrun.
            if (!r_receive || rx_done) begin
              w_rx_data_next = r_rx_shift;
              w_receive_next = 1'b1;
            end else begin
              w_rx_overrun_next = 1'b1;
            end
          end else begin
            w_rx_frame_err_next = 1'b1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + C_ONE;
        end
      end
      default: begin
        w_rx_state_next = R_IDLE;
        w_rx_cnt_next   = '0;
        w_rx_bit_next   = '0;
      end
    endcase
  end

  assign rx_data      = r_rx_data;
  assign receive      = r_receive;
  assign rx_frame_err = r_rx_frame_err;
  assign rx_overrun   = r_rx_overrun;

endmodule
